lfa_adc_reader: RTL
===================

Name: lfa_adc_reader

Overview:
- Upstream stage of the line follower. Drives the on-board ADC128S022 8-channel 12-bit SPI ADC and scans three line-follower-array (LFA) channels in round-robin.
- Presents registered 12-bit `left`/`middle`/`right` values that the line-following controller compares against its white/black thresholds.
- Runs entirely on `clk_3125KHz`; `adc_sck` is clk/2 (1.5625 MHz).

Parameters:
- CH_LEFT, 3, 3-bit ADC channel address of the left LFA sensor
- CH_MIDDLE, 2, 3-bit ADC channel address of the middle LFA sensor
- CH_RIGHT, 1, 3-bit ADC channel address of the right LFA sensor
- FRAME_GAP, 2, clocks with `adc_cs_n` high between frames (legal range 1..255)

Ports:
- clk_3125KHz  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  scan enable; low stops scanning after the current frame
- adc_dout  in  1  ADC serial data out (MISO)
- adc_cs_n  out  1  ADC chip select, active low
- adc_sck  out  1  ADC serial clock, idles high
- adc_din  out  1  ADC serial data in (MOSI), carries the channel address
- left  out  12  last left-sensor conversion
- middle  out  12  last middle-sensor conversion
- right  out  12  last right-sensor conversion
- ch_update  out  3  one-hot one-cycle pulse: [2]=left, [1]=middle, [0]=right register just written
- sample_valid  out  1  one-cycle pulse when `right` is written, which completes an L,M,R set

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - outputs: adc_cs_n=1, adc_sck=1, adc_din=0; left, middle, right = 0; ch_update=0; sample_valid=0.
  - internal state: FSM=IDLE, gap counter=0, slot=LEFT, prev_valid=0.
  - Applies identically mid-frame; the partial frame is abandoned and its data is never written.
- FSM IDLE:
  - adc_cs_n=1, adc_sck=1; the gap counter counts up each clock.
  - When the count reaches FRAME_GAP and en=1: go to XFER, adc_cs_n=0, bit index=0, phase=0.
  - With en=0 the FSM stays in IDLE with the counter held at FRAME_GAP.
- FSM XFER: 16 bits, 2 clocks per bit, 32 clocks total. For bit i (i = 0..15, MSB first):
  - Phase 0: adc_sck=0 and adc_din = control bit i. The control word has bits 2,3,4 = ADD2,ADD1,ADD0 of the current slot's channel; all other bits are 0.
  - Phase 1: adc_sck=1. On the same clock edge that sets adc_sck to 1, adc_dout is shifted into a 16-bit receive register.
  - After bit 15 phase 1: go to LATCH.
  - `en` is ignored during XFER; a started frame always completes.
- FSM LATCH (1 clock):
  - adc_cs_n=1, adc_sck=1.
  - If prev_valid=1, received bits [11:0] are written to the register of prev_slot, and the matching ch_update bit pulses for this one cycle. sample_valid pulses when prev_slot=RIGHT.
  - Received bits [15:12] (the ADC leading zeros) are discarded and not checked.
  - Then prev_slot<=slot, slot advances LEFT->MIDDLE->RIGHT->LEFT, prev_valid<=1, gap counter<=0, go to IDLE.
- Pipeline rule: the ADC converts the channel addressed in the previous frame. Data from frame k belongs to the slot addressed in frame k-1. The first frame after reset (or after a stop) returns an unknown channel and is discarded.
- Frame period is FRAME_GAP+33 clocks. The first sample_valid comes at the end of the 4th frame after reset.
- Stop/restart: if en is low when IDLE completes its gap, prev_valid is cleared. Scanning restarts with slot unchanged and its first frame is discarded.
- Output hold: left, middle, right hold their values between updates and while en=0.
- Never: adc_sck must never toggle while adc_cs_n=1, and ch_update must never have more than one bit set.

Test Plan:
- Reset, en=1, FRAME_GAP=2; ADC model returns ch3=0xABC, ch2=0x123, ch1=0x7FF -> ch_update=100 at frame 2 LATCH (left=0xABC), 010 at frame 3 (middle=0x123), 001 plus sample_valid at frame 4 (right=0x7FF); LATCH cycles 35 clocks apart.
- Check adc_din per frame -> address bits 011, 010, 001, 011 in bit positions 2-4; adc_sck: 16 low/high pairs per cs_n-low window; cs_n low exactly 32 clocks.
- Drop en mid-XFER -> frame completes and its LATCH writes; cs_n stays high afterwards and outputs hold. Re-raise en -> first frame writes nothing; the next frame updates the slot addressed by that discarded frame.
- Assert rst_n=0 at bit 7 of a frame -> next cycle cs_n=1, sck=1, all outputs 0. After release, the first ch_update does not occur before the 2nd frame.
- ADC model changes ch2 to 0x000 then 0xFFF -> middle follows with exactly one frame of pipeline delay; the full 12-bit range is passed with no truncation.
- FRAME_GAP=1 -> frame period is 34 clocks; sample_valid period is 102 clocks.

Source files
------------

// File: rtl/lfa_adc_reader.sv
// ADC128S022 scanner for the line-follower array.
// Round-robins three channels and registers left/middle/right.
module lfa_adc_reader #(
  parameter logic [2:0] CH_LEFT   = 3'd3,
  parameter logic [2:0] CH_MIDDLE = 3'd2,
  parameter logic [2:0] CH_RIGHT  = 3'd1,
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic        clk_3125KHz,
  input  logic        rst_n,
  input  logic        en,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  output logic [11:0] left,
  output logic [11:0] middle,
  output logic [11:0] right,
  output logic [2:0]  ch_update,
  output logic        sample_valid
);

  localparam logic [7:0] GAP = 8'(FRAME_GAP);

  typedef enum logic [1:0] {IDLE, XFER, LATCH} state_e;
  typedef enum logic [1:0] {S_LEFT, S_MIDDLE, S_RIGHT} slot_e;

  state_e      state_q, state_d;
  slot_e       slot_q, slot_d, prev_q, prev_d;
  logic        pv_q, pv_d;
  logic [7:0]  gap_q, gap_d, gap_inc;
  logic [3:0]  bit_q, bit_d;
  logic        ph_q, ph_d;
  logic [11:0] rx_q, rx_d;
  logic        cs_q, cs_d, sck_q, sck_d, din_q, din_d;
  logic [11:0] left_q, left_d, mid_q, mid_d, right_q, right_d;
  logic [2:0]  upd_q, upd_d;
  logic        sv_q, sv_d;
  logic [2:0]  addr;
  logic [15:0] ctrl;

  always_comb begin
    case (slot_q)
      S_MIDDLE: addr = CH_MIDDLE;
      S_RIGHT:  addr = CH_RIGHT;
      default:  addr = CH_LEFT;
    endcase
  end

  assign ctrl    = {2'b00, addr, 11'd0};
  assign gap_inc = (gap_q == GAP) ? gap_q : gap_q + 8'd1;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    rx_d    = rx_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    din_d   = din_q;
    left_d  = left_q;
    mid_d   = mid_q;
    right_d = right_q;
    upd_d   = 3'b000;
    sv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        gap_d = gap_inc;
        if (gap_inc == GAP) begin
          if (en) begin
            state_d = XFER;
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            din_d   = ctrl[15];
            bit_d   = 4'd0;
            ph_d    = 1'b0;
          end else begin
            pv_d = 1'b0;
          end
        end
      end
      XFER: begin
        if (!ph_q) begin
          ph_d  = 1'b1;
          sck_d = 1'b1;
          // 12-bit shifter: the four leading zeros fall off the top
          rx_d  = {rx_q[10:0], adc_dout};
        end else if (bit_q == 4'd15) begin
          state_d = LATCH;
          cs_d    = 1'b1;
          sck_d   = 1'b1;
          din_d   = 1'b0;
          if (pv_q) begin
            case (prev_q)
              S_MIDDLE: begin
                mid_d = rx_q;
                upd_d = 3'b010;
              end
              S_RIGHT: begin
                right_d = rx_q;
                upd_d   = 3'b001;
                sv_d    = 1'b1;
              end
              default: begin
                left_d = rx_q;
                upd_d  = 3'b100;
              end
            endcase
          end
        end else begin
          ph_d  = 1'b0;
          sck_d = 1'b0;
          bit_d = bit_q + 4'd1;
          din_d = ctrl[4'd14 - bit_q];
        end
      end
      LATCH: begin
        prev_d  = slot_q;
        pv_d    = 1'b1;
        gap_d   = 8'd0;
        state_d = IDLE;
        case (slot_q)
          S_LEFT:   slot_d = S_MIDDLE;
          S_MIDDLE: slot_d = S_RIGHT;
          default:  slot_d = S_LEFT;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= S_LEFT;
      prev_q  <= S_LEFT;
      pv_q    <= 1'b0;
      gap_q   <= 8'd0;
      bit_q   <= 4'd0;
      ph_q    <= 1'b0;
      rx_q    <= 12'd0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      din_q   <= 1'b0;
      left_q  <= 12'd0;
      mid_q   <= 12'd0;
      right_q <= 12'd0;
      upd_q   <= 3'b000;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      din_q   <= din_d;
      left_q  <= left_d;
      mid_q   <= mid_d;
      right_q <= right_d;
      upd_q   <= upd_d;
      sv_q    <= sv_d;
    end
  end

  assign adc_cs_n     = cs_q;
  assign adc_sck      = sck_q;
  assign adc_din      = din_q;
  assign left         = left_q;
  assign middle       = mid_q;
  assign right        = right_q;
  assign ch_update    = upd_q;
  assign sample_valid = sv_q;

endmodule
